// File: rtl/io_trace_capture.sv
`default_nettype none
// ============================================================================
// Module      : io_trace_capture
// Description : Pin-level trace harness. Registers host stimulus onto ui_in,
//               arms on a masked uo_out trigger, then logs every uo_out change
//               with a timestamp into a FIFO drained over valid/ready.
//               Build option IO_TRACE_DELTA_EN: saturating per-entry delta
//               timestamps instead of an absolute wrapping timestamp.
// Revision    : 1.0 - initial release
// ============================================================================
module io_trace_capture #(
  parameter int IN_W  = 8,
  parameter int OUT_W = 8,
  parameter int DEPTH = 16,
  parameter int TS_W  = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      ena,
  input  logic [IN_W-1:0]           stim_in,
  output logic [IN_W-1:0]           ui_in,
  input  logic [OUT_W-1:0]          uo_out,
  input  logic                      arm,
  input  logic                      clear,
  input  logic [OUT_W-1:0]          trig_mask,
  input  logic [OUT_W-1:0]          trig_value,
  output logic [TS_W+OUT_W-1:0]     trace_data,
  output logic                      trace_valid,
  input  logic                      trace_ready,
  output logic [$clog2(DEPTH):0]    trace_count,
  output logic                      overflow,
  output logic [1:0]                state
);

  localparam int                  c_PTR_W = $clog2(DEPTH);
  localparam int                  c_ENT_W = TS_W + OUT_W;
  localparam logic [c_PTR_W:0]    c_FULL  = (c_PTR_W + 1)'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ARMED   = 2'd1,
    S_CAPTURE = 2'd2
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [IN_W-1:0]      r_ui_in;
  logic [OUT_W-1:0]     r_s;
  logic [OUT_W-1:0]     r_prev;
  logic [TS_W-1:0]      r_ts;
  logic [TS_W-1:0]      w_ts_inc;
  logic [TS_W-1:0]      w_ts_nxt;
  logic [TS_W-1:0]      w_stamp;
  logic                 w_trig;
  logic                 w_push;
  logic                 w_push_ok;
  logic                 w_pop;
  logic                 w_full;
  logic [c_ENT_W-1:0]   r_mem [DEPTH];
  logic [c_PTR_W-1:0]   r_wr_ptr;
  logic [c_PTR_W-1:0]   r_rd_ptr;
  logic [c_PTR_W:0]     r_count;
  logic                 r_ovf;

  assign w_trig    = ((r_s ^ trig_value) & trig_mask) == '0;
  assign w_full    = (r_count == c_FULL);
  assign w_pop     = trace_valid && trace_ready;
  // A full FIFO still accepts a push when the head leaves on the same edge.
  assign w_push_ok = w_push && (!w_full || w_pop);

`ifdef IO_TRACE_DELTA_EN
  assign w_ts_inc = (r_ts == {TS_W{1'b1}}) ? r_ts : r_ts + TS_W'(1);
`else
  assign w_ts_inc = r_ts + TS_W'(1);
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_push      = 1'b0;
    w_stamp     = '0;
    w_ts_nxt    = r_ts;
    if (ena) begin
      unique case (r_state)
        S_IDLE: begin
          if (arm) w_state_nxt = S_ARMED;
        end
        S_ARMED: begin
          if (w_trig) begin
            w_state_nxt = S_CAPTURE;
            w_push      = 1'b1;
            w_ts_nxt    = '0;
          end
        end
        S_CAPTURE: begin
          w_stamp = w_ts_inc;
          w_push  = (r_s != r_prev);
`ifdef IO_TRACE_DELTA_EN
          // Delta restarts only once an entry actually lands in the FIFO.
          w_ts_nxt = w_push_ok ? '0 : w_ts_inc;
`else
          w_ts_nxt = w_ts_inc;
`endif
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_ui_in  <= '0;
      r_s      <= '0;
      r_prev   <= '0;
      r_state  <= S_IDLE;
      r_ts     <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_ovf    <= 1'b0;
    end else begin
      r_ui_in <= stim_in;
      r_s     <= uo_out;
      r_prev  <= r_s;
      if (clear) begin
        r_state  <= S_IDLE;
        r_ts     <= '0;
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
        r_count  <= '0;
        r_ovf    <= 1'b0;
      end else begin
        r_state <= w_state_nxt;
        r_ts    <= w_ts_nxt;
        if (w_push_ok) r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
        if (w_pop)     r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
        case ({w_push_ok, w_pop})
          2'b10:   r_count <= r_count + (c_PTR_W + 1)'(1);
          2'b01:   r_count <= r_count - (c_PTR_W + 1)'(1);
          default: r_count <= r_count;
        endcase
        if (w_push && !w_push_ok) r_ovf <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n && !clear && w_push_ok) begin
      r_mem[r_wr_ptr] <= {w_stamp, r_s};
    end
  end

  assign ui_in       = r_ui_in;
  assign trace_data  = r_mem[r_rd_ptr];
  assign trace_valid = (r_count != '0);
  assign trace_count = r_count;
  assign overflow    = r_ovf;
  assign state       = r_state;

endmodule
`default_nettype wire

// File: tb/tb_io_trace_capture.sv
`default_nettype none
// ============================================================================
// Module      : tb_io_trace_capture
// Description : Self-checking bench for io_trace_capture against a queue model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_io_trace_capture;

  localparam int IN_W  = 8;
  localparam int OUT_W = 8;
  localparam int DEPTH = 16;
  localparam int TS_W  = 4;
  localparam int D_W   = TS_W + OUT_W;
  localparam int TSMAX = (1 << TS_W) - 1;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic                 ena;
  logic [IN_W-1:0]      stim_in;
  logic [IN_W-1:0]      ui_in;
  logic [OUT_W-1:0]     uo_out;
  logic                 arm;
  logic                 clear;
  logic [OUT_W-1:0]     trig_mask;
  logic [OUT_W-1:0]     trig_value;
  logic [D_W-1:0]       trace_data;
  logic                 trace_valid;
  logic                 trace_ready;
  logic [$clog2(DEPTH):0] trace_count;
  logic                 overflow;
  logic [1:0]           state;

  always #5 clk = ~clk;

  io_trace_capture #(
    .IN_W(IN_W), .OUT_W(OUT_W), .DEPTH(DEPTH), .TS_W(TS_W)
  ) u_dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .stim_in(stim_in), .ui_in(ui_in),
    .uo_out(uo_out), .arm(arm), .clear(clear), .trig_mask(trig_mask),
    .trig_value(trig_value), .trace_data(trace_data), .trace_valid(trace_valid),
    .trace_ready(trace_ready), .trace_count(trace_count), .overflow(overflow),
    .state(state)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: observed %0h expected %0h (t=%0t)", tag, obs, exp, $time);
  endtask

  // Reference model: FIFO as a queue, time as plain integer cycle counts.
  logic [D_W-1:0]   m_q[$];
  int               m_state;
  logic [OUT_W-1:0] m_s, m_prev;
  logic [IN_W-1:0]  m_ui;
  bit               m_ovf;
  int               m_elapsed, m_since;

  task automatic model_step();
    bit       push, popped, full;
    int       nstate, stamp;
    if (!rst_n) begin
      m_q.delete();
      m_state = 0; m_s = '0; m_prev = '0; m_ui = '0; m_ovf = 0;
      m_elapsed = 0; m_since = 0;
      return;
    end
    push = 0; stamp = 0; nstate = m_state;
    if (ena) begin
      if (m_state == 0 && arm) nstate = 1;
      else if (m_state == 1 && ((m_s & trig_mask) == (trig_value & trig_mask))) begin
        nstate = 2; push = 1; stamp = 0; m_elapsed = 0; m_since = 0;
      end else if (m_state == 2) begin
        m_elapsed++; m_since++;
`ifdef IO_TRACE_DELTA_EN
        stamp = (m_since > TSMAX) ? TSMAX : m_since;
`else
        stamp = m_elapsed % (TSMAX + 1);
`endif
        push = (m_s != m_prev);
      end
    end
    if (clear) begin
      m_q.delete(); m_ovf = 0; m_state = 0; m_elapsed = 0; m_since = 0;
    end else begin
      full   = (m_q.size() == DEPTH);
      popped = (m_q.size() != 0) && trace_ready;
      if (popped) void'(m_q.pop_front());
      if (push) begin
        if (!full || popped) begin
          m_q.push_back(D_W'((stamp << OUT_W) | int'(m_s)));
          m_since = 0;
        end else m_ovf = 1;
      end
      m_state = nstate;
    end
    m_prev = m_s;
    m_s    = uo_out;
    m_ui   = stim_in;
  endtask

  task automatic compare_all();
    check_eq("ui_in", 32'(ui_in), 32'(m_ui));
    check_eq("trace_valid", 32'(trace_valid), 32'(m_q.size() != 0));
    check_eq("trace_count", 32'(trace_count), 32'(m_q.size()));
    check_eq("overflow", 32'(overflow), 32'(m_ovf));
    check_eq("state", 32'(state), 32'(m_state));
    if (m_q.size() != 0) check_eq("trace_data", 32'(trace_data), 32'(m_q[0]));
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  logic [D_W-1:0] exp_wrap;
  int quiet, en_off;

  initial begin
    rst_n = 1'b0; ena = 1'b1; stim_in = '0; uo_out = '0; arm = 1'b0; clear = 1'b0;
    trig_mask = '0; trig_value = '0; trace_ready = 1'b0;
    ticks(2);
    check_eq("rst_valid", 32'(trace_valid), 32'd0);
    check_eq("rst_count", 32'(trace_count), 32'd0);
    check_eq("rst_state", 32'(state), 32'd0);
    check_eq("rst_ovf", 32'(overflow), 32'd0);
    rst_n = 1'b1;

    // Stimulus pass-through and IDLE ignores uo_out activity.
    stim_in = 8'hA5; tick();
    check_eq("ui_in_A5", 32'(ui_in), 32'hA5);
    for (int i = 0; i < 5; i++) begin uo_out = 8'(i * 37); tick(); end
    uo_out = 8'h00; ticks(2);
    check_eq("idle_no_push", 32'(trace_valid), 32'd0);

    // Masked trigger on bit 7, then a change five cycles later.
    trig_mask = 8'h80; trig_value = 8'h80;
    arm = 1'b1; tick(); arm = 1'b0;
    ticks(2);
    uo_out = 8'h80; ticks(5);
    uo_out = 8'h81; ticks(3);
    check_eq("cap_state", 32'(state), 32'd2);
    check_eq("cap_count", 32'(trace_count), 32'd2);
    // Backpressure: head holds for four cycles, then one pop.
    for (int i = 0; i < 4; i++) begin
      tick();
      check_eq("hold_data", 32'(trace_data), 32'h080);
    end
    trace_ready = 1'b1; tick(); trace_ready = 1'b0;
    check_eq("pop_count", 32'(trace_count), 32'd1);
    check_eq("second_entry", 32'(trace_data), 32'h581);

    // Overflow: zero mask triggers immediately, then keep changing.
    clear = 1'b1; tick(); clear = 1'b0;
    trig_mask = 8'h00; trig_value = 8'h00;
    arm = 1'b1; tick(); arm = 1'b0;
    for (int i = 0; i < 17; i++) begin uo_out = 8'(8'h40 + i); tick(); end
    check_eq("ovf_count", 32'(trace_count), 32'(DEPTH));
    check_eq("ovf_flag", 32'(overflow), 32'd1);
    uo_out = 8'h7E; trace_ready = 1'b1; tick();
    check_eq("full_pushpop", 32'(trace_count), 32'(DEPTH));
    ticks(10);
    trace_ready = 1'b0;

    // Clear wins over a same-cycle push and pop.
    uo_out = 8'h11; tick();
    uo_out = 8'h12; trace_ready = 1'b1; clear = 1'b1; tick();
    clear = 1'b0; trace_ready = 1'b0;
    check_eq("clr_count", 32'(trace_count), 32'd0);
    check_eq("clr_ovf", 32'(overflow), 32'd0);
    check_eq("clr_state", 32'(state), 32'd0);
    check_eq("clr_valid", 32'(trace_valid), 32'd0);

    // Timestamp wrap: changes 3 and 19 cycles after trigger.
    uo_out = 8'h10; ticks(2);
    arm = 1'b1; tick(); arm = 1'b0;
    tick();                       // trigger edge
    tick();
    uo_out = 8'h22; tick(); tick();
    ticks(14);
    uo_out = 8'h33; tick(); tick();
    check_eq("wrap_trig", 32'(trace_data), 32'h010);
    trace_ready = 1'b1; tick(); trace_ready = 1'b0;
    check_eq("wrap_first", 32'(trace_data), 32'h322);
    trace_ready = 1'b1; tick(); trace_ready = 1'b0;
`ifdef IO_TRACE_DELTA_EN
    exp_wrap = 12'hF33;
`else
    exp_wrap = 12'h333;
`endif
    check_eq("wrap_second", 32'(trace_data), 32'(exp_wrap));

    // Randomised traffic against the model.
    quiet = 0; en_off = 0;
    clear = 1'b1; tick(); clear = 1'b0;
    for (int t = 0; t < 1500; t++) begin
      stim_in = 8'($urandom);
      rst_n   = ($urandom_range(0, 299) != 0);
      arm = 1'b0; clear = 1'b0;
      if (!rst_n) begin
        ena = 1'b1; quiet = 0; en_off = 0;
      end else if (en_off > 0) begin
        ena = 1'b0; trace_ready = 1'b0; en_off--; quiet++;
      end else if (quiet >= 2 && $urandom_range(0, 19) == 0) begin
        ena = 1'b0; trace_ready = 1'b0; en_off = $urandom_range(0, 2); quiet++;
      end else begin
        ena = 1'b1;
        trace_ready = $urandom_range(0, 1) == 1;
        arm   = ($urandom_range(0, 14) == 0);
        clear = ($urandom_range(0, 79) == 0);
        if ($urandom_range(0, 49) == 0) begin
          trig_mask  = 8'($urandom) & 8'h07;
          trig_value = 8'($urandom);
        end
        if ($urandom_range(0, 2) == 0) begin
          uo_out = 8'($urandom); quiet = 0;
        end else quiet++;
      end
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
